// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: opcode encodings, flag bit
// positions and the packed flag register type.
package alu_pkg;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_ADC  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_SBC  = 3'd3;
   localparam logic [2:0] ALU_AND  = 3'd4;
   localparam logic [2:0] ALU_OR   = 3'd5;
   localparam logic [2:0] ALU_XOR  = 3'd6;
   localparam logic [2:0] ALU_PASS = 3'd7;

   localparam int unsigned FLAG_C = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_V = 0;

   // Field order matches FLAG_* indices: c is the MSB.
   typedef struct packed {
      logic c;
      logic z;
      logic n;
      logic v;
   } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU core: computes the result and the candidate flags from the
// shifted LHS, the RHS, the opcode and the registered carry.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       op_i,
   input  logic             c_i,
   input  logic             lcarry_i,
   output logic [WIDTH-1:0] r_o,
   output alu_flags_t       flags_o
);

   logic [WIDTH-1:0] b_eff;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic             c_new;
   logic             v_new;

   always_comb begin
      b_eff = ((op_i == ALU_SUB) || (op_i == ALU_SBC)) ? ~b_i : b_i;
      cin   = 1'b0;
      unique case (op_i)
         ALU_ADC, ALU_SBC: cin = c_i;
         ALU_SUB:          cin = 1'b1;
         default:          cin = 1'b0;
      endcase
      sum = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

      r_o   = '0;
      c_new = c_i;
      v_new = 1'b0;
      unique case (op_i)
         ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC: begin
            r_o   = sum[WIDTH-1:0];
            c_new = sum[WIDTH];
            v_new = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (r_o[WIDTH-1] != a_i[WIDTH-1]);
         end
         ALU_AND:  r_o = a_i & b_i;
         ALU_OR:   r_o = a_i | b_i;
         ALU_XOR:  r_o = a_i ^ b_i;
         ALU_PASS: begin
            r_o   = a_i;
            c_new = lcarry_i;
         end
         default:  r_o = '0;
      endcase

      flags_o   = '0;
      flags_o.c = c_new;
      flags_o.z = (r_o == '0);
      flags_o.n = r_o[WIDTH-1];
      flags_o.v = v_new;
   end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result pipeline stage: registers the ALU result and owns the C/Z/N/V
// flag register, with Flush taking priority over Stall.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             AluClock,
   input  logic             nReset,
   input  logic [WIDTH-1:0] Shift,
   input  logic             LCarryOut,
   input  logic [WIDTH-1:0] RHS,
   input  logic [2:0]       AluOp,
   input  logic             FlagWrite,
   input  logic             InValid,
   input  logic             Stall,
   input  logic             Flush,
   output logic [WIDTH-1:0] Result,
   output logic             OutValid,
   output logic [3:0]       Flags,
   output logic             CarryFlag
);

   logic [WIDTH-1:0] result_q, result_d;
   logic             out_valid_q, out_valid_d;
   alu_flags_t       flags_q, flags_d;

   logic [WIDTH-1:0] core_r;
   alu_flags_t       core_flags;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a_i      (Shift),
      .b_i      (RHS),
      .op_i     (AluOp),
      .c_i      (flags_q.c),
      .lcarry_i (LCarryOut),
      .r_o      (core_r),
      .flags_o  (core_flags)
   );

   always_comb begin
      result_d    = result_q;
      out_valid_d = out_valid_q;
      flags_d     = flags_q;
      if (Flush) begin
         out_valid_d = 1'b0;
      end else if (Stall) begin
         out_valid_d = out_valid_q;
      end else if (InValid) begin
         result_d    = core_r;
         out_valid_d = 1'b1;
         if (FlagWrite) begin
            flags_d = core_flags;
         end
      end else begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge AluClock or negedge nReset) begin
      if (!nReset) begin
         result_q    <= '0;
         out_valid_q <= 1'b0;
         flags_q     <= '0;
      end else begin
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         flags_q     <= flags_d;
      end
   end

   assign Result    = result_q;
   assign OutValid  = out_valid_q;
   assign Flags     = flags_q;
   assign CarryFlag = flags_q.c;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: driver pushes expected post-edge state
// from an arithmetic reference model; a monitor pops and compares.
module tb_alu_result_stage;
   import alu_pkg::*;

   logic       AluClock;
   logic       nReset;
   logic [7:0] Shift;
   logic       LCarryOut;
   logic [7:0] RHS;
   logic [2:0] AluOp;
   logic       FlagWrite;
   logic       InValid;
   logic       Stall;
   logic       Flush;
   logic [7:0] Result;
   logic       OutValid;
   logic [3:0] Flags;
   logic       CarryFlag;

   alu_result_stage #(
      .WIDTH (8)
   ) dut (
      .AluClock  (AluClock),
      .nReset    (nReset),
      .Shift     (Shift),
      .LCarryOut (LCarryOut),
      .RHS       (RHS),
      .AluOp     (AluOp),
      .FlagWrite (FlagWrite),
      .InValid   (InValid),
      .Stall     (Stall),
      .Flush     (Flush),
      .Result    (Result),
      .OutValid  (OutValid),
      .Flags     (Flags),
      .CarryFlag (CarryFlag)
   );

   initial AluClock = 1'b0;
   always #5 AluClock = ~AluClock;

   typedef struct {
      int res;
      int ov;
      int c;
      int z;
      int n;
      int v;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model state
   int m_res, m_ov, m_c, m_z, m_n, m_v;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int sgn(input int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   task automatic push_state();
      exp_t e;
      e.res = m_res; e.ov = m_ov;
      e.c = m_c; e.z = m_z; e.n = m_n; e.v = m_v;
      exp_q.push_back(e);
   endtask

   // Advance the model by one edge using the currently driven inputs.
   task automatic model_step();
      int a, b, r, c, v, sv, full;
      a = int'(Shift);
      b = int'(RHS);
      c = m_c;
      v = 0;
      r = 0;
      if (!nReset) begin
         m_res = 0; m_ov = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
      end else if (Flush) begin
         m_ov = 0;
      end else if (Stall) begin
         m_ov = m_ov;
      end else if (InValid) begin
         case (AluOp)
            ALU_ADD: begin full = a + b; sv = sgn(a) + sgn(b); end
            ALU_ADC: begin full = a + b + m_c; sv = sgn(a) + sgn(b) + m_c; end
            ALU_SUB: begin full = a - b; sv = sgn(a) - sgn(b); end
            ALU_SBC: begin full = a - b - (1 - m_c); sv = sgn(a) - sgn(b) - (1 - m_c); end
            default: begin full = 0; sv = 0; end
         endcase
         case (AluOp)
            ALU_ADD, ALU_ADC: begin
               r = full % 256; c = (full > 255) ? 1 : 0;
               v = (sv > 127 || sv < -128) ? 1 : 0;
            end
            ALU_SUB, ALU_SBC: begin
               r = (full + 256) % 256; c = (full >= 0) ? 1 : 0;
               v = (sv > 127 || sv < -128) ? 1 : 0;
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            default: begin r = a; c = int'(LCarryOut); end
         endcase
         m_res = r;
         m_ov  = 1;
         if (FlagWrite) begin
            m_c = c; m_z = (r == 0) ? 1 : 0; m_n = (r >= 128) ? 1 : 0; m_v = v;
         end
      end else begin
         m_ov = 0;
      end
   endtask

   task automatic cycle(input logic [2:0] op, input logic [7:0] sh, input logic lc,
                        input logic [7:0] rh, input logic fw, input logic inv,
                        input logic st, input logic fl);
      @(negedge AluClock);
      AluOp = op; Shift = sh; LCarryOut = lc; RHS = rh;
      FlagWrite = fw; InValid = inv; Stall = st; Flush = fl;
      model_step();
      push_state();
   endtask

   task automatic idle();
      cycle(ALU_ADD, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Async reset asserted between edges, held across one edge, then released.
   task automatic mid_reset();
      @(posedge AluClock);
      #3;
      m_res = 0; m_ov = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
      push_state();
      nReset = 1'b0;
      cycle(ALU_ADD, 8'h55, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge AluClock);
      nReset = 1'b1;
      InValid = 1'b0; Stall = 1'b0; Flush = 1'b0;
      model_step();
      push_state();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge AluClock or negedge nReset);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("Result", int'(Result), e.res);
            chk("OutValid", int'(OutValid), e.ov);
            chk("Flags", int'(Flags), e.c * 8 + e.z * 4 + e.n * 2 + e.v);
            chk("CarryFlag", int'(CarryFlag), e.c);
         end
      end
   end

   initial begin : driver
      nReset = 1'b0;
      AluOp = ALU_ADD; Shift = '0; LCarryOut = 1'b0; RHS = '0;
      FlagWrite = 1'b0; InValid = 1'b0; Stall = 1'b0; Flush = 1'b0;
      m_res = 0; m_ov = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
      // Reset state held across two edges
      cycle(ALU_ADD, 8'h12, 1'b1, 8'h34, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle(ALU_ADD, 8'h12, 1'b1, 8'h34, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge AluClock);
      nReset = 1'b1;
      InValid = 1'b0;
      model_step();
      push_state();

      // Signed overflow on ADD
      cycle(ALU_ADD, 8'h7F, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
      // SUB to zero, then borrow
      cycle(ALU_SUB, 8'h10, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle(ALU_SUB, 8'h00, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
      // Carry chain into back-to-back ADC
      cycle(ALU_ADD, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle(ALU_ADC, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      // SBC with C=0 then C=1
      cycle(ALU_SBC, 8'h05, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle(ALU_SBC, 8'h80, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
      // PASS takes LCarryOut; AND without flag write
      cycle(ALU_PASS, 8'h02, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle(ALU_AND, 8'hF0, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(ALU_XOR, 8'hF0, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0);
      // Stall freezes everything, Flush beats Stall and blocks the flag write
      cycle(ALU_ADD, 8'h40, 1'b0, 8'h41, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(3'(i), 8'($urandom), 1'b1, 8'($urandom), 1'b1, 1'b1, 1'b1, 1'b0);
      end
      cycle(ALU_ADD, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
      idle();
      // Reset mid-stream, then normal op
      cycle(ALU_ADD, 8'hC0, 1'b0, 8'hC0, 1'b1, 1'b1, 1'b0, 1'b0);
      mid_reset();
      cycle(ALU_ADD, 8'h01, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
      idle();

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         if (i == 200) mid_reset();
         cycle(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom),
               ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
               ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
               ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
               ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0,
               ($urandom_range(0, 9) < 1) ? 1'b1 : 1'b0);
      end
      idle();
      @(posedge AluClock);
      #3;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Pipeline stage directly downstream of the ALU left-hand-side shifter.
- Takes the shifter output Shift[7:0] and its carry LCarryOut, combines them with the RHS operand under an ALU opcode, and registers the result and the flags.
- Owns the architectural flag register (C, Z, N, V). Its registered carry flag feeds back as the shifter's LCarryIn and is also the ADC/SBC carry-in.

Parameters:
- WIDTH, 8, datapath width in bits. Flags are computed from bit WIDTH-1.

Ports:
- AluClock  in  1  stage clock; all state updates on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Shift  in  WIDTH  shifted LHS operand from the shifter.
- LCarryOut  in  1  bit shifted out by the shifter.
- RHS  in  WIDTH  right-hand operand.
- AluOp  in  3  operation select (encoding below).
- FlagWrite  in  1  when high, the accepted operation updates the flag register.
- InValid  in  1  input operation is valid this cycle.
- Stall  in  1  hold the stage.
- Flush  in  1  discard the input and invalidate the output.
- Result  out  WIDTH  registered result.
- OutValid  out  1  Result holds a completed operation.
- Flags  out  4  registered {C,Z,N,V}, MSB = C.
- CarryFlag  out  1  equals Flags[3]; wired to the shifter's LCarryIn.

Behaviour:
- Reset (nReset low, asynchronous): Result=0, OutValid=0, Flags=4'b0000. Reset takes effect immediately, including mid-stall. The first edge after release behaves normally.
- AluOp encoding:
  - 0 ADD: A+B
  - 1 ADC: A+B+C
  - 2 SUB: A+~B+1
  - 3 SBC: A+~B+C
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 PASS: Result=A, where A=Shift and B=RHS
- Arithmetic:
  - Computed at WIDTH+1 bits; C_new = bit WIDTH, so C=1 means no borrow on SUB/SBC.
  - V_new = (A[W-1]==B'[W-1]) && (R[W-1]!=A[W-1]), where B' is the inverted B for SUB/SBC.
- Logic ops (AND, OR, XOR): C unchanged, V_new=0.
- PASS: C_new = LCarryOut, V_new=0.
- All ops: Z_new=(R==0), N_new=R[W-1].
- Accept condition: accept = InValid && !Stall && !Flush.
- On each rising edge, in priority order:
  - Flush=1: OutValid<=0; Result and Flags unchanged; no flag write even if FlagWrite=1. Flush overrides Stall.
  - else Stall=1: Result, OutValid and Flags all hold.
  - else accept: Result<=R, OutValid<=1; Flags<=new flags only if FlagWrite=1, else Flags hold.
  - else (InValid=0): OutValid<=0; Result and Flags hold.
- Latency: 1 cycle, input edge to Result/OutValid. Throughput: 1 op per cycle.
- Back-to-back ADC/SBC uses the C written by the previous accepted op, because the flags update on the same edge as the result. No forwarding path is needed.
- Carry-in for ADC/SBC is the registered C only; LCarryOut is never used as an adder carry-in.
- CarryFlag is driven purely from the register. There is no combinational path from any input to any output.

Decomposition:
- Shared package alu_pkg holds:
  - AluOp encodings: ALU_ADD..ALU_PASS.
  - Flag bit indices: FLAG_C=3, FLAG_Z=2, FLAG_N=1, FLAG_V=0.
  - The flags typedef.
- One combinational sub-module, alu_core, computes R and the new flags from A, B, AluOp, C_in and LCarryOut.
- The top level holds the pipeline and flag registers and the Stall/Flush priority logic.

Test Plan:
- ADD, Shift=8'h7F, RHS=8'h01, FlagWrite=1 -> next edge Result=8'h80, OutValid=1, Flags C=0 Z=0 N=1 V=1.
- SUB 8'h10-8'h10, then SUB 8'h00-8'h01 -> 8'h00 with C=1 Z=1; then 8'hFF with C=0 N=1 V=0.
- Carry chain: ADD 8'hFF+8'h01 -> 8'h00, C=1. Next cycle ADC 8'h00+8'h00 -> 8'h01, C=0. CarryFlag tracks C each edge.
- PASS with Shift=8'h02, LCarryOut=1 -> Result=8'h02, C=1, V=0. Then AND 8'hF0&8'h0F with FlagWrite=0 -> Result=8'h00, Flags unchanged.
- Stall: ADD accepted, then Stall=1 for 3 cycles with changing inputs -> Result, OutValid and Flags frozen. Stall=1 with Flush=1 -> OutValid=0 next edge, Flags unchanged.
- Reset mid-stream: drive nReset low between edges -> Result=0, OutValid=0, Flags=0 immediately. After release, ADD 8'h01+8'h01 -> 8'h02 one edge later.
